// File: rtl/fifo_sync_w2n.sv
// Single-clock wide-to-narrow FIFO: DWI-bit words in, DWI/DWO DWO-bit words out, LS slice first.
// Define FIFO_W2N_FWFT_EN for first-word-fall-through (combinational) read data.
module fifo_sync_w2n #(
    parameter int DWI = 16,
    parameter int AWI = 6,
    parameter int DWO = 8,
    parameter int AWO = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [DWI-1:0]   wr_data,
    input  logic             rd_en,
    output logic [DWO-1:0]   rd_data,
    output logic             full,
    output logic             almost_full,
    output logic [AWI:0]     wr_data_cnt,
    output logic             empty,
    output logic             almost_empty,
    output logic [AWO:0]     rd_data_cnt
);

    localparam int R     = DWI / DWO;
    localparam int LOG2R = $clog2(R);
    localparam int DEPTH = 1 << AWI;

    logic [AWI:0]     wr_ptr_q, wr_ptr_d;
    logic [AWO:0]     rd_ptr_q, rd_ptr_d;
    logic [DWI-1:0]   mem_q [DEPTH];

    logic             wr_acc;
    logic             rd_acc;
    logic [AWO:0]     wr_ptr_narrow;
    logic [AWI:0]     rd_ptr_wide;
    logic [AWI-1:0]   rd_addr;
    logic [LOG2R-1:0] rd_sel;
    logic [DWO-1:0]   rd_word;

    // Pointers scaled into each other's units; wrap-around falls out of the modular subtraction.
    assign wr_ptr_narrow = {wr_ptr_q, {LOG2R{1'b0}}};
    assign rd_ptr_wide   = rd_ptr_q[AWO:LOG2R];

    assign rd_data_cnt  = wr_ptr_narrow - rd_ptr_q;
    assign wr_data_cnt  = wr_ptr_q - rd_ptr_wide;
    assign full         = (wr_data_cnt == (AWI+1)'(DEPTH));
    assign almost_full  = (wr_data_cnt >= (AWI+1)'(DEPTH - 1));
    assign empty        = (rd_data_cnt == '0);
    assign almost_empty = (rd_data_cnt <= (AWO+1)'(1));

    assign rd_addr = rd_ptr_q[AWO-1:LOG2R];
    assign rd_sel  = rd_ptr_q[LOG2R-1:0];
    assign rd_word = mem_q[rd_addr][DWO*int'(rd_sel) +: DWO];

    always_comb begin
        wr_acc   = wr_en && !full;
        rd_acc   = rd_en && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + (AWI+1)'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + (AWO+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q[AWI-1:0]] <= wr_data;
        end
    end

`ifdef FIFO_W2N_FWFT_EN
    assign rd_data = rd_word;
`else
    logic [DWO-1:0] rd_data_q, rd_data_d;

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_acc) begin
            rd_data_d = rd_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_fifo_sync_w2n.sv
// Scoreboard bench for fifo_sync_w2n: a queue-of-bytes reference model predicts counts, flags and read data.
module tb_fifo_sync_w2n;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_data;
    logic        full, almost_full, empty, almost_empty;
    logic [6:0]  wr_data_cnt;
    logic [7:0]  rd_data_cnt;

    int errors = 0;
    int checks = 0;

    fifo_sync_w2n dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .full         (full),
        .almost_full  (almost_full),
        .wr_data_cnt  (wr_data_cnt),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rd_data_cnt  (rd_data_cnt)
    );

    always #5 clk = ~clk;

    // Reference: FIFO of narrow words; a wide slot is occupied while any of its bytes remain.
    logic [7:0] mq[$];
    logic [7:0] exp_rd[$];
    logic [7:0] hold_exp = 8'h00;

    function automatic int model_wcnt();
        return (mq.size() + 1) / 2;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    bit wa, ra;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            exp_rd.delete();
            hold_exp = 8'h00;
        end else begin
            wa = wr_en && (model_wcnt() != 64);
            ra = rd_en && (mq.size() != 0);
            if (ra) exp_rd.push_back(mq.pop_front());
            if (wa) begin
                mq.push_back(wr_data[7:0]);
                mq.push_back(wr_data[15:8]);
            end
        end
    end

    always @(negedge clk) begin
        check("rd_data_cnt", 32'(rd_data_cnt), 32'(mq.size()));
        check("wr_data_cnt", 32'(wr_data_cnt), 32'(model_wcnt()));
        check("empty", 32'(empty), 32'(mq.size() == 0));
        check("full", 32'(full), 32'(model_wcnt() == 64));
        check("almost_empty", 32'(almost_empty), 32'(mq.size() <= 1));
        check("almost_full", 32'(almost_full), 32'(model_wcnt() >= 63));
        check("empty_and_full", 32'(empty && full), 32'(0));
`ifdef FIFO_W2N_FWFT_EN
        if (mq.size() != 0) check("rd_data", 32'(rd_data), 32'(mq[0]));
        exp_rd.delete();
`else
        if (exp_rd.size() != 0) hold_exp = exp_rd.pop_front();
        check("rd_data", 32'(rd_data), 32'(hold_exp));
`endif
    end

    task automatic cyc(input bit w, input logic [15:0] d, input bit r);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_rd_data", 32'(rd_data), 32'(0));
        check("reset_empty", 32'(empty), 32'(1));
        cyc(0, 16'h0, 0);
        cyc(0, 16'h0, 0);

        // unpack order
        cyc(1, 16'h1201, 0);
        cyc(0, 16'h0, 1);
        cyc(0, 16'h0, 1);
        cyc(0, 16'h0, 0);

        // fill, overfill, read while full with a same-edge write
        for (int i = 0; i < 64; i++) cyc(1, 16'(i), 0);
        cyc(1, 16'hFFFF, 0);
        cyc(0, 16'h0, 1);
        cyc(1, 16'hAAAA, 1);
        repeat (130) cyc(0, 16'h0, 1);

        // empty boundary
        cyc(1, 16'h3456, 1);
        cyc(0, 16'h0, 0);
        repeat (3) cyc(0, 16'h0, 1);

        // streaming with an async reset pulse mid-stream
        for (int n = 0; n < 200; n++) begin
            cyc(1, 16'(16'h0100 + n), 1);
            cyc(0, 16'h0, 1);
            if (n == 100) begin
                #2 rst_n = 1'b0;
                #1;
                check("async_rst_empty", 32'(empty), 32'(1));
                check("async_rst_almost_empty", 32'(almost_empty), 32'(1));
                check("async_rst_full", 32'(full), 32'(0));
                check("async_rst_almost_full", 32'(almost_full), 32'(0));
                check("async_rst_rd_cnt", 32'(rd_data_cnt), 32'(0));
                check("async_rst_wr_cnt", 32'(wr_data_cnt), 32'(0));
`ifndef FIFO_W2N_FWFT_EN
                check("async_rst_rd_data", 32'(rd_data), 32'(0));
`endif
                @(posedge clk);
                @(posedge clk);
                #1 rst_n = 1'b1;
            end
        end
        repeat (4) cyc(0, 16'h0, 1);

        // random traffic: write-heavy then read-heavy
        repeat (1500) cyc($urandom_range(0, 99) < 80, 16'($urandom), $urandom_range(0, 99) < 40);
        repeat (1500) cyc($urandom_range(0, 99) < 30, 16'($urandom), $urandom_range(0, 99) < 80);
        repeat (140) cyc(0, 16'h0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
